// File: rtl/write_response_route_table.sv
`default_nettype none
// ============================================================================
//  Module   : write_response_route_table
//  Brief    : Tracks the source master of accepted AW beats by AWID and
//             routes slave-side B responses back to the owning master.
//             Entries are freed as responses retire. New AW acceptance is
//             gated when no entry or counter headroom is left.
//  Revision : 1.0 - initial release
// ============================================================================
module write_response_route_table #(
   parameter  int ID_W    = 6,
   parameter  int NUM_MST = 3,
   parameter  int DEPTH   = 4,
   parameter  int CNT_W   = 4,
   localparam int MST_W   = (NUM_MST > 1) ? $clog2(NUM_MST) : 1,
   localparam int OUT_W   = CNT_W + $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst_n,
   // AW observation toward the slave
   input  logic [ID_W-1:0]    aw_id,
   input  logic [MST_W-1:0]   aw_src,
   input  logic               aw_valid,
   input  logic               aw_ready,
   output logic               aw_allow,
   // B channel from the slave
   input  logic [ID_W-1:0]    s_bid,
   input  logic [1:0]         s_bresp,
   input  logic               s_bvalid,
   output logic               s_bready,
   // B channel toward the masters
   output logic [ID_W-1:0]    m_bid,
   output logic [1:0]         m_bresp,
   output logic [NUM_MST-1:0] m_bvalid,
   input  logic [NUM_MST-1:0] m_bready,
   // Status
   output logic [OUT_W-1:0]   outstanding,
   output logic               unmatched
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Table state, one slot per tracked ID
   logic             r_vld [DEPTH];
   logic [ID_W-1:0]  r_id  [DEPTH];
   logic [MST_W-1:0] r_src [DEPTH];
   logic [CNT_W-1:0] r_cnt [DEPTH];

   logic [OUT_W-1:0] r_out;
   logic             r_unmatched;

   // Lookup results
   logic             w_aw_hit;
   logic [IDX_W-1:0] w_aw_idx;
   logic             w_b_hit;
   logic [IDX_W-1:0] w_b_idx;
   logic             w_free_any;
   logic [IDX_W-1:0] w_free_idx;

   // Derived control
   logic [MST_W-1:0] w_bsrc;
   logic [CNT_W-1:0] w_aw_cnt;
   logic             w_sel_ready;
   logic             w_aw_rec;
   logic             w_b_ret;
   logic [DEPTH-1:0] w_rec_vec;
   logic [DEPTH-1:0] w_ret_vec;

   // CAM-style lookup of aw_id and s_bid plus lowest-index free slot search;
   // scanning from the top down lets the lowest matching index win.
   always_comb begin
      w_aw_hit   = 1'b0;
      w_aw_idx   = '0;
      w_b_hit    = 1'b0;
      w_b_idx    = '0;
      w_free_any = 1'b0;
      w_free_idx = '0;
      for (int e = DEPTH - 1; e >= 0; e--) begin
         if (r_vld[e] && (r_id[e] == aw_id)) begin
            w_aw_hit = 1'b1;
            w_aw_idx = IDX_W'(e);
         end
         if (r_vld[e] && (r_id[e] == s_bid)) begin
            w_b_hit = 1'b1;
            w_b_idx = IDX_W'(e);
         end
         if (!r_vld[e]) begin
            w_free_any = 1'b1;
            w_free_idx = IDX_W'(e);
         end
      end
   end

   assign w_bsrc   = r_src[w_b_idx];
   assign w_aw_cnt = r_cnt[w_aw_idx];

   // An existing ID may only grow while its counter has headroom; a new ID
   // needs a free slot. Both are judged from pre-edge state only.
   assign aw_allow = w_aw_hit ? (w_aw_cnt != {CNT_W{1'b1}}) : w_free_any;
   assign w_aw_rec = aw_valid & aw_ready & aw_allow;

   // Zero-latency B steering: one-hot valid to the owning master, its ready
   // back to the slave. Unknown IDs are drained so the slave never stalls.
   always_comb begin
      m_bvalid    = '0;
      w_sel_ready = 1'b0;
      for (int m = 0; m < NUM_MST; m++) begin
         if (w_b_hit && (w_bsrc == MST_W'(m))) begin
            m_bvalid[m] = s_bvalid;
            w_sel_ready = m_bready[m];
         end
      end
      s_bready = w_b_hit ? w_sel_ready : s_bvalid;
   end

   assign m_bid   = s_bid;
   assign m_bresp = s_bresp;
   assign w_b_ret = s_bvalid & s_bready & w_b_hit;

   // Per-slot record/retire strobes
   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      assign w_rec_vec[e] = w_aw_rec &
                            (w_aw_hit ? (w_aw_idx == IDX_W'(e))
                                      : (w_free_idx == IDX_W'(e)));
      assign w_ret_vec[e] = w_b_ret & (w_b_idx == IDX_W'(e));
   end

   // Table update: record bumps or allocates, retire decrements and frees at
   // zero; a record and retire on the same slot cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) begin
            r_vld[e] <= 1'b0;
            r_id[e]  <= '0;
            r_src[e] <= '0;
            r_cnt[e] <= '0;
         end
      end else begin
         for (int e = 0; e < DEPTH; e++) begin
            if (w_rec_vec[e] && !w_ret_vec[e]) begin
               if (w_aw_hit) begin
                  r_cnt[e] <= r_cnt[e] + CNT_W'(1);
               end else begin
                  r_vld[e] <= 1'b1;
                  r_id[e]  <= aw_id;
                  r_src[e] <= aw_src;
                  r_cnt[e] <= CNT_W'(1);
               end
            end else if (w_ret_vec[e] && !w_rec_vec[e]) begin
               r_cnt[e] <= r_cnt[e] - CNT_W'(1);
               if (r_cnt[e] == CNT_W'(1)) begin
                  r_vld[e] <= 1'b0;
               end
            end
         end
      end
   end

   // Running total of writes awaiting a response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
      end else begin
         r_out <= r_out + OUT_W'(w_aw_rec) - OUT_W'(w_b_ret);
      end
   end

   // Sticky flag for responses whose BID is not in the table
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_unmatched <= 1'b0;
      end else if (s_bvalid && !w_b_hit) begin
         r_unmatched <= 1'b1;
      end
   end

   assign outstanding = r_out;
   assign unmatched   = r_unmatched;

endmodule
`default_nettype wire

// File: tb/tb_write_response_route_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_write_response_route_table
//  Brief    : Self-checking bench for write_response_route_table. A reference
//             table keyed by ID predicts acceptance and routing; expected B
//             routing results are queued when driven and popped on compare.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_write_response_route_table;

   localparam int ID_W    = 6;
   localparam int NUM_MST = 3;
   localparam int DEPTH   = 4;
   localparam int CNT_W   = 4;
   localparam int MST_W   = 2;
   localparam int OUT_W   = 7;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [ID_W-1:0]    aw_id;
   logic [MST_W-1:0]   aw_src;
   logic               aw_valid;
   logic               aw_ready;
   logic               aw_allow;
   logic [ID_W-1:0]    s_bid;
   logic [1:0]         s_bresp;
   logic               s_bvalid;
   logic               s_bready;
   logic [ID_W-1:0]    m_bid;
   logic [1:0]         m_bresp;
   logic [NUM_MST-1:0] m_bvalid;
   logic [NUM_MST-1:0] m_bready;
   logic [OUT_W-1:0]   outstanding;
   logic               unmatched;

   always #5 clk = ~clk;

   write_response_route_table #(
      .ID_W(ID_W), .NUM_MST(NUM_MST), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .aw_id(aw_id), .aw_src(aw_src), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .aw_allow(aw_allow),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .outstanding(outstanding), .unmatched(unmatched)
   );

   typedef struct packed {
      logic [NUM_MST-1:0] bv;
      logic               br;
      logic [ID_W-1:0]    bid;
      logic [1:0]         resp;
   } exp_t;

   exp_t sb_q[$];
   int   mcnt[int];
   int   msrc[int];
   int   m_out;
   bit   m_unm;
   int   n_checks;
   int   n_errors;

   function automatic bit exp_allow();
      if (mcnt.exists(int'(aw_id))) return mcnt[int'(aw_id)] < 15;
      return mcnt.num() < DEPTH;
   endfunction

   task automatic idle();
      aw_valid = 1'b0;
      aw_ready = 1'b0;
      s_bvalid = 1'b0;
      m_bready = '0;
   endtask

   task automatic drive_aw(input int id, input int src);
      aw_id    = ID_W'(id);
      aw_src   = MST_W'(src);
      aw_valid = 1'b1;
      aw_ready = 1'b1;
   endtask

   task automatic drive_b(input int id, input int resp, input logic [NUM_MST-1:0] rdy);
      exp_t e;
      s_bid    = ID_W'(id);
      s_bresp  = 2'(resp);
      s_bvalid = 1'b1;
      m_bready = rdy;
      if (mcnt.exists(id)) begin
         e.bv = NUM_MST'(1) << msrc[id];
         e.br = rdy[msrc[id]];
      end else begin
         e.bv = '0;
         e.br = 1'b1;
      end
      e.bid  = ID_W'(id);
      e.resp = 2'(resp);
      sb_q.push_back(e);
   endtask

   // Advance the reference model by one edge using the currently driven inputs
   task automatic commit();
      int a, b;
      bit allow, hit_b, rec, ret;
      a     = int'(aw_id);
      b     = int'(s_bid);
      allow = exp_allow();
      rec   = aw_valid && aw_ready && allow;
      hit_b = mcnt.exists(b);
      ret   = 1'b0;
      if (hit_b) ret = s_bvalid && m_bready[msrc[b]];
      if (s_bvalid && !hit_b) m_unm = 1'b1;
      if (!(rec && ret && a == b)) begin
         if (ret) begin
            mcnt[b]--;
            if (mcnt[b] == 0) begin
               mcnt.delete(b);
               msrc.delete(b);
            end
         end
         if (rec) begin
            if (mcnt.exists(a)) mcnt[a]++;
            else begin
               mcnt[a] = 1;
               msrc[a] = int'(aw_src);
            end
         end
      end
      m_out = m_out + int'(rec) - int'(ret);
      @(posedge clk);
   endtask

   task automatic model_clear();
      mcnt.delete();
      msrc.delete();
      m_out = 0;
      m_unm = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n   = 1'b0;
      idle();
      aw_id   = '0;
      aw_src  = '0;
      s_bid   = '0;
      s_bresp = '0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      n_checks++;
      if (aw_allow !== 1'b1) begin n_errors++; $display("FAIL reset_aw_allow got %b want 1", aw_allow); end
      n_checks++;
      if (m_bvalid !== 3'b000) begin n_errors++; $display("FAIL reset_m_bvalid got %b want 000", m_bvalid); end
      n_checks++;
      if (s_bready !== 1'b0) begin n_errors++; $display("FAIL reset_s_bready got %b want 0", s_bready); end
      n_checks++;
      if (outstanding !== 7'd0) begin n_errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
      n_checks++;
      if (unmatched !== 1'b0) begin n_errors++; $display("FAIL reset_unmatched got %b want 0", unmatched); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_route();
      exp_t e;
      @(negedge clk); idle(); drive_aw(5, 2); #1;
      n_checks++;
      if (aw_allow !== 1'b1) begin n_errors++; $display("FAIL single_allow got %b want 1", aw_allow); end
      commit();
      @(negedge clk); idle(); #1;
      n_checks++;
      if (outstanding !== 7'd1) begin n_errors++; $display("FAIL single_out1 got %0d want 1", outstanding); end
      drive_b(5, 0, 3'b100); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
         begin n_errors++; $display("FAIL single_route got %b want %b", {m_bvalid, s_bready, m_bid, m_bresp}, e); end
      commit();
      @(negedge clk); idle(); #1;
      n_checks++;
      if (outstanding !== 7'd0) begin n_errors++; $display("FAIL single_out0 got %0d want 0", outstanding); end
   endtask

   task automatic test_capacity();
      exp_t e;
      int   drain_ids[5] = '{1, 2, 2, 3, 4};
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); idle(); drive_aw(i, i % 3); #1;
         n_checks++;
         if (aw_allow !== 1'b1) begin n_errors++; $display("FAIL cap_allow_%0d got %b want 1", i, aw_allow); end
         commit();
      end
      @(negedge clk); idle(); drive_aw(6, 0); #1;
      n_checks++;
      if (aw_allow !== 1'b0) begin n_errors++; $display("FAIL cap_full_allow got %b want 0", aw_allow); end
      commit();
      @(negedge clk); idle(); drive_aw(2, 2); #1;
      n_checks++;
      if (aw_allow !== 1'b1) begin n_errors++; $display("FAIL cap_hit_allow got %b want 1", aw_allow); end
      commit();
      @(negedge clk); idle(); #1;
      n_checks++;
      if (outstanding !== 7'd5) begin n_errors++; $display("FAIL cap_out got %0d want 5", outstanding); end
      foreach (drain_ids[i]) begin
         @(negedge clk); idle(); drive_b(drain_ids[i], i % 4, 3'b111); #1;
         e = sb_q.pop_front();
         n_checks++;
         if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
            begin n_errors++; $display("FAIL cap_route_%0d got %b want %b", i, {m_bvalid, s_bready, m_bid, m_bresp}, e); end
         commit();
      end
      @(negedge clk); idle(); drive_aw(6, 0); aw_valid = 1'b0; #1;
      n_checks++;
      if (outstanding !== 7'(m_out) || aw_allow !== 1'b1)
         begin n_errors++; $display("FAIL cap_drained got out=%0d allow=%b want out=%0d allow=1", outstanding, aw_allow, m_out); end
   endtask

   task automatic test_counter_full();
      exp_t e;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk); idle(); drive_aw(9, 1); #1;
         n_checks++;
         if (aw_allow !== 1'b1) begin n_errors++; $display("FAIL cnt_allow_%0d got %b want 1", i, aw_allow); end
         commit();
      end
      @(negedge clk); idle(); drive_aw(9, 1); #1;
      n_checks++;
      if (aw_allow !== 1'b0 || outstanding !== 7'd15)
         begin n_errors++; $display("FAIL cnt_sat got allow=%b out=%0d want allow=0 out=15", aw_allow, outstanding); end
      commit();
      // Master not ready: response must stall at the slave
      @(negedge clk); idle(); drive_b(9, 2, 3'b000); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
         begin n_errors++; $display("FAIL cnt_stall got %b want %b", {m_bvalid, s_bready, m_bid, m_bresp}, e); end
      commit();
      @(negedge clk); idle(); drive_b(9, 2, 3'b010); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
         begin n_errors++; $display("FAIL cnt_retire got %b want %b", {m_bvalid, s_bready, m_bid, m_bresp}, e); end
      commit();
      @(negedge clk); idle(); aw_id = 6'd9; #1;
      n_checks++;
      if (aw_allow !== 1'b1 || outstanding !== 7'd14)
         begin n_errors++; $display("FAIL cnt_reopen got allow=%b out=%0d want allow=1 out=14", aw_allow, outstanding); end
      for (int i = 0; i < 14; i++) begin
         @(negedge clk); idle(); drive_b(9, 0, 3'b010); #1;
         e = sb_q.pop_front();
         n_checks++;
         if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
            begin n_errors++; $display("FAIL cnt_drain_%0d got %b want %b", i, {m_bvalid, s_bready, m_bid, m_bresp}, e); end
         commit();
      end
      @(negedge clk); idle(); #1;
      n_checks++;
      if (outstanding !== 7'd0) begin n_errors++; $display("FAIL cnt_out0 got %0d want 0", outstanding); end
   endtask

   task automatic test_same_cycle();
      exp_t e;
      int   rest[4] = '{11, 12, 14, 15};
      @(negedge clk); idle(); drive_aw(7, 0); #1;
      commit();
      @(negedge clk); idle(); drive_aw(7, 0); drive_b(7, 1, 3'b001); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
         begin n_errors++; $display("FAIL same_route got %b want %b", {m_bvalid, s_bready, m_bid, m_bresp}, e); end
      commit();
      @(negedge clk); idle(); #1;
      n_checks++;
      if (outstanding !== 7'd1) begin n_errors++; $display("FAIL same_out got %0d want 1", outstanding); end
      // Entry must still be live: this response routes rather than drops
      drive_b(7, 0, 3'b001); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({m_bvalid, s_bready, m_bid, m_bresp} !== e || m_bvalid !== 3'b001)
         begin n_errors++; $display("FAIL same_still_valid got %b want %b", {m_bvalid, s_bready, m_bid, m_bresp}, e); end
      commit();
      // Retire frees slot X while a new ID takes a different free slot
      for (int i = 10; i <= 12; i++) begin
         @(negedge clk); idle(); drive_aw(i, 1); #1; commit();
      end
      @(negedge clk); idle(); drive_aw(14, 2); drive_b(10, 0, 3'b010); #1;
      n_checks++;
      if (aw_allow !== 1'b1) begin n_errors++; $display("FAIL swap_allow got %b want 1", aw_allow); end
      void'(sb_q.pop_front());
      commit();
      @(negedge clk); idle(); drive_aw(15, 0); #1;
      n_checks++;
      if (aw_allow !== 1'b1) begin n_errors++; $display("FAIL swap_reuse got %b want 1", aw_allow); end
      commit();
      @(negedge clk); idle(); drive_aw(20, 0); aw_valid = 1'b0; #1;
      n_checks++;
      if (aw_allow !== 1'b0 || outstanding !== 7'd4)
         begin n_errors++; $display("FAIL swap_full got allow=%b out=%0d want allow=0 out=4", aw_allow, outstanding); end
      foreach (rest[i]) begin
         @(negedge clk); idle(); drive_b(rest[i], 3, 3'b111); #1;
         e = sb_q.pop_front();
         n_checks++;
         if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
            begin n_errors++; $display("FAIL swap_route_%0d got %b want %b", rest[i], {m_bvalid, s_bready, m_bid, m_bresp}, e); end
         commit();
      end
      @(negedge clk); idle(); #1;
      n_checks++;
      if (outstanding !== 7'(m_out)) begin n_errors++; $display("FAIL swap_out got %0d want %0d", outstanding, m_out); end
   endtask

   task automatic test_unmatched();
      exp_t e;
      @(negedge clk); idle(); drive_aw(6'h21, 1); #1; commit();
      @(negedge clk); idle(); drive_b(6'h3F, 3, 3'b111); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({m_bvalid, s_bready, m_bid, m_bresp} !== e || s_bready !== 1'b1 || m_bvalid !== 3'b000)
         begin n_errors++; $display("FAIL unm_drop got %b want %b", {m_bvalid, s_bready, m_bid, m_bresp}, e); end
      commit();
      @(negedge clk); idle(); #1;
      n_checks++;
      if (unmatched !== 1'b1) begin n_errors++; $display("FAIL unm_set got %b want 1", unmatched); end
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (unmatched !== 1'b1 || outstanding !== 7'd1)
         begin n_errors++; $display("FAIL unm_sticky got unm=%b out=%0d want unm=1 out=1", unmatched, outstanding); end
      // Asynchronous reset mid-operation clears everything at once
      rst_n = 1'b0; #1;
      model_clear();
      n_checks++;
      if (unmatched !== 1'b0 || outstanding !== 7'd0 || aw_allow !== 1'b1)
         begin n_errors++; $display("FAIL midreset got unm=%b out=%0d allow=%b want 0/0/1", unmatched, outstanding, aw_allow); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); idle(); drive_b(6'h21, 0, 3'b010); #1;
      e = sb_q.pop_front();
      n_checks++;
      if ({m_bvalid, s_bready, m_bid, m_bresp} !== e)
         begin n_errors++; $display("FAIL stale_route got %b want %b", {m_bvalid, s_bready, m_bid, m_bresp}, e); end
      commit();
      @(negedge clk); idle(); #1;
      n_checks++;
      if (unmatched !== 1'(m_unm)) begin n_errors++; $display("FAIL stale_unm got %b want %b", unmatched, m_unm); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      test_reset();
      test_single_route();
      test_capacity();
      test_counter_full();
      test_same_cycle();
      test_unmatched();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
